// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the 5-stage RV32I core.
// Arbitrates jump redirects, load-use bubbles, multi-cycle execute freezes
// and debug halt. Hold/flush/redirect outputs are combinational from the
// inputs and current state; busy/ack flags are registered from state.
// Optional feature macro: PIPE_CTRL_MC_TIMEOUT_EN (MC_WAIT abort after
// MC_TIMEOUT cycles, reported on mc_err_o).
module pipe_ctrl
`ifdef PIPE_CTRL_MC_TIMEOUT_EN
#(
    parameter int unsigned MC_TIMEOUT = 64
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_used_i,
    input  logic        id_rs2_used_i,
    input  logic [4:0]  idex_rd_addr_i,
    input  logic        idex_reg_wen_i,
    input  logic        idex_is_load_i,
    input  logic        mc_start_i,
    input  logic        mc_done_i,
    input  logic        halt_req_i,
    output logic        pc_load_o,
    output logic [31:0] pc_target_o,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        mc_busy_o,
    output logic        halt_ack_o,
    output logic        mc_err_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   load_use;
    logic   rs1_hit;
    logic   rs2_hit;
    logic   timeout_hit;

    // Hazard detect: load in id_ex writing a register that decode reads.
    always_comb begin
        rs1_hit  = id_rs1_used_i && (idex_rd_addr_i == id_rs1_addr_i);
        rs2_hit  = id_rs2_used_i && (idex_rd_addr_i == id_rs2_addr_i);
        load_use = idex_is_load_i && idex_reg_wen_i &&
                   (idex_rd_addr_i != 5'd0) && (rs1_hit || rs2_hit);
    end

`ifdef PIPE_CTRL_MC_TIMEOUT_EN
    logic [15:0] mc_cnt;
    logic        mc_err_q;

    // Count cycles spent in MC_WAIT; cleared whenever we are elsewhere, so
    // every entry from RUN starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_cnt <= '0;
        end else if (state == MC_WAIT) begin
            mc_cnt <= mc_cnt + 16'd1;
        end else begin
            mc_cnt <= '0;
        end
    end

    // Abort in the MC_TIMEOUT-th wait cycle unless the unit finishes then.
    assign timeout_hit = (state == MC_WAIT) && !mc_done_i &&
                         (mc_cnt == 16'(MC_TIMEOUT - 1));

    // One-cycle error pulse following the abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_err_q <= 1'b0;
        end else begin
            mc_err_q <= timeout_hit;
        end
    end

    assign mc_err_o = mc_err_q;
`else
    assign timeout_hit = 1'b0;
    assign mc_err_o    = 1'b0;
`endif

    // Priority arbitration of hold/flush/redirect and next-state selection.
    always_comb begin
        state_nxt     = state;
        pc_load_o     = 1'b0;
        pc_target_o   = '0;
        hold_pc_o     = 1'b0;
        hold_if_id_o  = 1'b0;
        hold_id_ex_o  = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        case (state)
            RUN: begin
                if (jump_en_i) begin
                    pc_load_o     = 1'b1;
                    pc_target_o   = jump_addr_i;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end else if (mc_start_i) begin
                    hold_pc_o    = 1'b1;
                    hold_if_id_o = 1'b1;
                    hold_id_ex_o = 1'b1;
                    state_nxt    = MC_WAIT;
                end else if (load_use) begin
                    hold_pc_o     = 1'b1;
                    hold_if_id_o  = 1'b1;
                    flush_id_ex_o = 1'b1;
                end else if (halt_req_i) begin
                    hold_pc_o     = 1'b1;
                    hold_if_id_o  = 1'b1;
                    flush_id_ex_o = 1'b1;
                    state_nxt     = HALT;
                end
            end
            MC_WAIT: begin
                if (mc_done_i) begin
                    state_nxt = RUN;
                end else if (timeout_hit) begin
                    flush_id_ex_o = 1'b1;
                    state_nxt     = RUN;
                end else begin
                    hold_pc_o    = 1'b1;
                    hold_if_id_o = 1'b1;
                    hold_id_ex_o = 1'b1;
                end
            end
            HALT: begin
                if (halt_req_i) begin
                    hold_pc_o    = 1'b1;
                    hold_if_id_o = 1'b1;
                    hold_id_ex_o = 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // State register with busy/ack flags registered from the next state so
    // they equal a decode of the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            mc_busy_o  <= 1'b0;
            halt_ack_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            mc_busy_o  <= (state_nxt == MC_WAIT);
            halt_ack_o <= (state_nxt == HALT);
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (hold_pc_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl. Each row drives one cycle of
// inputs and pushes the expected outputs; they are popped and compared at the
// falling edge of the same cycle.
module tb_pipe_ctrl;

    typedef struct packed {
        logic        jump;
        logic [31:0] addr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        wen;
        logic        load;
        logic        start;
        logic        done;
        logic        halt;
    } in_t;

    typedef struct {
        logic [8:0]  f;
        logic [31:0] tgt;
        logic [31:0] stall;
    } exp_t;

    typedef struct {
        in_t         s;
        logic [8:0]  f;
        logic [31:0] t;
    } row_t;

    // Flag order: pc_load, hold_pc, hold_if_id, hold_id_ex, flush_if_id,
    // flush_id_ex, mc_busy, halt_ack, mc_err
    localparam logic [8:0] F_IDLE  = 9'b0_000_00_000;
    localparam logic [8:0] F_JUMP  = 9'b1_000_11_000;
    localparam logic [8:0] F_MCST  = 9'b0_111_00_000;
    localparam logic [8:0] F_MCW   = 9'b0_111_00_100;
    localparam logic [8:0] F_MCD   = 9'b0_000_00_100;
    localparam logic [8:0] F_LU    = 9'b0_110_01_000;
    localparam logic [8:0] F_HREQ  = 9'b0_110_01_000;
    localparam logic [8:0] F_HALT  = 9'b0_111_00_010;
    localparam logic [8:0] F_HREL  = 9'b0_000_00_010;
    localparam logic [8:0] F_TMO   = 9'b0_000_01_100;
    localparam logic [8:0] F_ERR   = 9'b0_000_00_001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    in_t  stim = '0;

    logic        pc_load_o;
    logic [31:0] pc_target_o;
    logic        hold_pc_o, hold_if_id_o, hold_id_ex_o;
    logic        flush_if_id_o, flush_id_ex_o;
    logic        mc_busy_o, halt_ack_o, mc_err_o;
    logic [31:0] stall_cnt_o;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_stall = '0;

    always #5 clk = ~clk;

`ifdef PIPE_CTRL_MC_TIMEOUT_EN
    pipe_ctrl #(.MC_TIMEOUT(8)) dut (
`else
    pipe_ctrl dut (
`endif
        .clk            (clk),
        .rst_n          (rst_n),
        .jump_en_i      (stim.jump),
        .jump_addr_i    (stim.addr),
        .id_rs1_addr_i  (stim.rs1),
        .id_rs2_addr_i  (stim.rs2),
        .id_rs1_used_i  (stim.u1),
        .id_rs2_used_i  (stim.u2),
        .idex_rd_addr_i (stim.rd),
        .idex_reg_wen_i (stim.wen),
        .idex_is_load_i (stim.load),
        .mc_start_i     (stim.start),
        .mc_done_i      (stim.done),
        .halt_req_i     (stim.halt),
        .pc_load_o      (pc_load_o),
        .pc_target_o    (pc_target_o),
        .hold_pc_o      (hold_pc_o),
        .hold_if_id_o   (hold_if_id_o),
        .hold_id_ex_o   (hold_id_ex_o),
        .flush_if_id_o  (flush_if_id_o),
        .flush_id_ex_o  (flush_id_ex_o),
        .mc_busy_o      (mc_busy_o),
        .halt_ack_o     (halt_ack_o),
        .mc_err_o       (mc_err_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    function automatic logic [72:0] observe();
        return {pc_load_o, hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o,
                flush_id_ex_o, mc_busy_o, halt_ack_o, mc_err_o, pc_target_o, stall_cnt_o};
    endfunction

    function automatic in_t nop();
        in_t s = '0;
        return s;
    endfunction

    function automatic in_t jmp(input logic [31:0] a);
        in_t s = '0;
        s.jump = 1'b1;
        s.addr = a;
        return s;
    endfunction

    function automatic in_t mcs();
        in_t s = '0;
        s.start = 1'b1;
        return s;
    endfunction

    function automatic in_t mcd();
        in_t s = '0;
        s.done = 1'b1;
        return s;
    endfunction

    function automatic in_t hrq();
        in_t s = '0;
        s.halt = 1'b1;
        return s;
    endfunction

    function automatic in_t lu(input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u1, input logic u2);
        in_t s = '0;
        s.load = 1'b1;
        s.wen  = 1'b1;
        s.rd   = rd;
        s.rs1  = rs1;
        s.rs2  = rs2;
        s.u1   = u1;
        s.u2   = u2;
        return s;
    endfunction

    function automatic row_t row(input in_t s, input logic [8:0] f, input logic [31:0] t);
        row_t r;
        r.s = s;
        r.f = f;
        r.t = t;
        return r;
    endfunction

    // Drive one cycle of stimulus and record what the DUT must show for it.
    task automatic drive(input row_t r);
        exp_t e;
        stim    = r.s;
        e.f     = r.f;
        e.tgt   = r.t;
        e.stall = exp_stall;
        sb.push_back(e);
        if (r.f[7]) exp_stall = exp_stall + 32'd1;
    endtask

    task automatic do_reset();
        stim  = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_stall = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        row_t        q[$];
        exp_t        e;
        logic [72:0] got;
        stim  = '0;
        rst_n = 1'b0;
        @(negedge clk);
        got = observe();
        n_cmp++;
        if (got !== 73'd0) begin
            n_fail++;
            $display("FAIL reset_initial got=%h exp=%h", got, 73'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_stall = '0;
        q.push_back(row(mcs(), F_MCST, 32'h0));
        q.push_back(row(nop(), F_MCW,  32'h0));
        q.push_back(row(nop(), F_MCW,  32'h0));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            got = observe();
            n_cmp++;
            if (got !== {e.f, e.tgt, e.stall}) begin
                n_fail++;
                $display("FAIL reset_pre[%0d] got=%h exp=%h", i, got, {e.f, e.tgt, e.stall});
            end
            @(posedge clk);
            #1;
        end
        // Asynchronous reset in the middle of MC_WAIT.
        stim = nop();
        #2 rst_n = 1'b0;
        @(negedge clk);
        got = observe();
        n_cmp++;
        if (got !== 73'd0) begin
            n_fail++;
            $display("FAIL reset_mid_mcwait got=%h exp=%h", got, 73'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_stall = '0;
        q.delete();
        q.push_back(row(nop(), F_IDLE, 32'h0));
        q.push_back(row(nop(), F_IDLE, 32'h0));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            got = observe();
            n_cmp++;
            if (got !== {e.f, e.tgt, e.stall}) begin
                n_fail++;
                $display("FAIL reset_post[%0d] got=%h exp=%h", i, got, {e.f, e.tgt, e.stall});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_jump();
        row_t        q[$];
        exp_t        e;
        logic [72:0] got;
        in_t         x;
        do_reset();
        x = jmp(32'h0000_0100);
        x.start = 1'b1;
        q.push_back(row(x, F_JUMP, 32'h0000_0100));
        q.push_back(row(nop(), F_IDLE, 32'h0));
        x = lu(5'd5, 5'd5, 5'd7, 1'b1, 1'b0);
        x.jump = 1'b1;
        x.addr = 32'hDEAD_BEEF;
        x.halt = 1'b1;
        q.push_back(row(x, F_JUMP, 32'hDEAD_BEEF));
        x = nop();
        x.addr = 32'h0000_1234;
        q.push_back(row(x, F_IDLE, 32'h0));
        q.push_back(row(jmp(32'h8000_0000), F_JUMP, 32'h8000_0000));
        q.push_back(row(jmp(32'h0000_0004), F_JUMP, 32'h0000_0004));
        q.push_back(row(nop(), F_IDLE, 32'h0));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            got = observe();
            n_cmp++;
            if (got !== {e.f, e.tgt, e.stall}) begin
                n_fail++;
                $display("FAIL jump[%0d] got=%h exp=%h", i, got, {e.f, e.tgt, e.stall});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        row_t        q[$];
        exp_t        e;
        logic [72:0] got;
        in_t         x;
        do_reset();
        q.push_back(row(lu(5'd5, 5'd5, 5'd7, 1'b1, 1'b0), F_LU, 32'h0));
        q.push_back(row(nop(), F_IDLE, 32'h0));
        q.push_back(row(lu(5'd0, 5'd0, 5'd7, 1'b1, 1'b0), F_IDLE, 32'h0));
        q.push_back(row(lu(5'd9, 5'd7, 5'd9, 1'b0, 1'b1), F_LU, 32'h0));
        q.push_back(row(lu(5'd9, 5'd9, 5'd9, 1'b0, 1'b0), F_IDLE, 32'h0));
        x = lu(5'd5, 5'd5, 5'd7, 1'b1, 1'b0);
        x.wen = 1'b0;
        q.push_back(row(x, F_IDLE, 32'h0));
        x = lu(5'd5, 5'd5, 5'd7, 1'b1, 1'b0);
        x.load = 1'b0;
        q.push_back(row(x, F_IDLE, 32'h0));
        x = lu(5'd31, 5'd31, 5'd1, 1'b1, 1'b1);
        x.halt = 1'b1;
        q.push_back(row(x, F_LU, 32'h0));
        q.push_back(row(hrq(), F_HREQ, 32'h0));
        q.push_back(row(hrq(), F_HALT, 32'h0));
        q.push_back(row(nop(), F_HREL, 32'h0));
        q.push_back(row(nop(), F_IDLE, 32'h0));
        x = lu(5'd5, 5'd5, 5'd7, 1'b1, 1'b0);
        x.start = 1'b1;
        q.push_back(row(x, F_MCST, 32'h0));
        q.push_back(row(mcd(), F_MCD, 32'h0));
        q.push_back(row(nop(), F_IDLE, 32'h0));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            got = observe();
            n_cmp++;
            if (got !== {e.f, e.tgt, e.stall}) begin
                n_fail++;
                $display("FAIL load_use[%0d] got=%h exp=%h", i, got, {e.f, e.tgt, e.stall});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_multicycle();
        row_t        q[$];
        exp_t        e;
        logic [72:0] got;
        in_t         x;
        do_reset();
        q.push_back(row(mcs(), F_MCST, 32'h0));
        q.push_back(row(jmp(32'h0000_0040), F_MCW, 32'h0));
        q.push_back(row(hrq(), F_MCW, 32'h0));
        q.push_back(row(nop(), F_MCW, 32'h0));
        q.push_back(row(mcs(), F_MCW, 32'h0));
        q.push_back(row(mcd(), F_MCD, 32'h0));
        q.push_back(row(nop(), F_IDLE, 32'h0));
        x = mcs();
        x.done = 1'b1;
        q.push_back(row(x, F_MCST, 32'h0));
        q.push_back(row(mcd(), F_MCD, 32'h0));
        q.push_back(row(nop(), F_IDLE, 32'h0));
`ifndef PIPE_CTRL_MC_TIMEOUT_EN
        // Without the abort feature MC_WAIT must hold indefinitely.
        q.push_back(row(mcs(), F_MCST, 32'h0));
        for (int k = 0; k < 80; k++) q.push_back(row(nop(), F_MCW, 32'h0));
        q.push_back(row(mcd(), F_MCD, 32'h0));
        q.push_back(row(nop(), F_IDLE, 32'h0));
`endif
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            got = observe();
            n_cmp++;
            if (got !== {e.f, e.tgt, e.stall}) begin
                n_fail++;
                $display("FAIL multicycle[%0d] got=%h exp=%h", i, got, {e.f, e.tgt, e.stall});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_halt();
        row_t        q[$];
        exp_t        e;
        logic [72:0] got;
        in_t         x;
        do_reset();
        q.push_back(row(hrq(), F_HREQ, 32'h0));
        q.push_back(row(hrq(), F_HALT, 32'h0));
        x = hrq();
        x.done = 1'b1;
        q.push_back(row(x, F_HALT, 32'h0));
        q.push_back(row(hrq(), F_HALT, 32'h0));
        q.push_back(row(nop(), F_HREL, 32'h0));
        q.push_back(row(nop(), F_IDLE, 32'h0));
        q.push_back(row(jmp(32'h0000_0200), F_JUMP, 32'h0000_0200));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            got = observe();
            n_cmp++;
            if (got !== {e.f, e.tgt, e.stall}) begin
                n_fail++;
                $display("FAIL halt[%0d] got=%h exp=%h", i, got, {e.f, e.tgt, e.stall});
            end
            @(posedge clk);
            #1;
        end
    endtask

`ifdef PIPE_CTRL_MC_TIMEOUT_EN
    task automatic test_timeout();
        row_t        q[$];
        exp_t        e;
        logic [72:0] got;
        do_reset();
        q.push_back(row(mcs(), F_MCST, 32'h0));
        for (int k = 0; k < 7; k++) q.push_back(row(nop(), F_MCW, 32'h0));
        q.push_back(row(nop(), F_TMO, 32'h0));
        q.push_back(row(nop(), F_ERR, 32'h0));
        q.push_back(row(nop(), F_IDLE, 32'h0));
        q.push_back(row(mcs(), F_MCST, 32'h0));
        for (int k = 0; k < 7; k++) q.push_back(row(nop(), F_MCW, 32'h0));
        q.push_back(row(mcd(), F_MCD, 32'h0));
        q.push_back(row(nop(), F_IDLE, 32'h0));
        q.push_back(row(nop(), F_IDLE, 32'h0));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            got = observe();
            n_cmp++;
            if (got !== {e.f, e.tgt, e.stall}) begin
                n_fail++;
                $display("FAIL timeout[%0d] got=%h exp=%h", i, got, {e.f, e.tgt, e.stall});
            end
            @(posedge clk);
            #1;
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_jump();
        test_load_use();
        test_multicycle();
        test_halt();
`ifdef PIPE_CTRL_MC_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
